// File: rtl/vmx_mm_sequencer.sv
// vmx_mm_sequencer: job sequencer for a weight-stationary PE array.
// It skews rows into the array, deskews products out and tags rows through to the write port.
module vmx_mm_sequencer #(
  parameter int PE_SIZE = 4,
  parameter int PORT_WIDTH = 16,
  parameter int ARRAY_LAT = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [CNT_WIDTH-1:0]              cfg_rows,
  input  logic                              cfg_simd,
  input  logic                              cfg_loop,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PE_SIZE*PORT_WIDTH-1:0]     d_i,
  output logic                              pe_en,
  output logic [8*PE_SIZE-1:0]              pe_ctrl,
  output logic [PE_SIZE-1:0]                pe_simd,
  output logic [PE_SIZE*PORT_WIDTH-1:0]     pe_vec,
  input  logic [2*PE_SIZE*PORT_WIDTH-1:0]   pe_prod,
  output logic                              wr_en,
  input  logic                              wr_ready,
  output logic [2*PE_SIZE*PORT_WIDTH-1:0]   d_o,
  output logic [CNT_WIDTH-1:0]              addr,
  output logic                              busy,
  output logic                              done,
  output logic [2:0]                        state_o
);
  localparam int L = 2*(PE_SIZE-1) + ARRAY_LAT;
  localparam int W = PORT_WIDTH;
  localparam int RW = 2*PORT_WIDTH;
  typedef enum logic [2:0] {IDLE = 3'd0, SETW = 3'd1, LOAD = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, rows_q, last_row;
  logic simd_q, weights_ok, hs, launch;
  logic [L-1:0] tags;
  logic [RW*PE_SIZE-1:0] res;
  assign pe_en = ~(wr_en & ~wr_ready);
  assign in_ready = (state == SETW || state == LOAD) && pe_en;
  assign hs = in_valid & in_ready;
  assign wr_en = tags[L-1];
  assign launch = state == IDLE && start && !abort;
  assign last_row = (state == SETW || rows_q == '0) ? CNT_WIDTH'(PE_SIZE-1) : rows_q - CNT_WIDTH'(1);
  assign d_o = wr_en ? res : '0;
  assign pe_simd = {PE_SIZE{simd_q}};
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign state_o = state;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (cfg_loop && weights_ok) ? LOAD : SETW;
      SETW:    if (hs && cnt == last_row) state_nx = LOAD;
      LOAD:    if (hs && cnt == last_row) state_nx = DRAIN;
      DRAIN:   if (tags == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rows_q <= '0;
      simd_q <= 1'b0;
      weights_ok <= 1'b0;
      tags <= '0;
      addr <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        cnt <= '0;
        tags <= '0;
        weights_ok <= 1'b0;
        addr <= '0;
      end else begin
        if (launch) begin
          rows_q <= cfg_rows;
          simd_q <= cfg_simd;
          cnt <= '0;
          addr <= '0;
          if (!(cfg_loop && weights_ok)) weights_ok <= 1'b0;
        end else begin
          if (wr_en && wr_ready) addr <= addr + CNT_WIDTH'(1);
          if (hs) cnt <= (cnt == last_row) ? '0 : cnt + CNT_WIDTH'(1);
        end
        if (hs && state == SETW && cnt == last_row) weights_ok <= 1'b1;
        if (pe_en) tags <= {tags[L-2:0], hs && state == LOAD};
      end
    end
  end
  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    localparam int D = PE_SIZE - 1 - i;
    logic [W-1:0] vin;
    logic [7:0] cin;
    assign vin = hs ? d_i[i*W +: W] : '0;
    assign cin = (hs && state == SETW) ? {1'b1, 7'(cnt)} : 8'd0;
    if (i == 0) begin : g_in0
      assign pe_vec[W-1:0] = vin;
      assign pe_ctrl[7:0] = cin;
    end else begin : g_inn
      logic [W-1:0] sv [i];
      logic [7:0] sc [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) begin sv[k] <= '0; sc[k] <= '0; end
        end else if (abort) begin
          for (int k = 0; k < i; k++) begin sv[k] <= '0; sc[k] <= '0; end
        end else if (pe_en) begin
          sv[0] <= vin;
          sc[0] <= cin;
          for (int k = 1; k < i; k++) begin sv[k] <= sv[k-1]; sc[k] <= sc[k-1]; end
        end
      end
      assign pe_vec[i*W +: W] = sv[i-1];
      assign pe_ctrl[8*i +: 8] = sc[i-1];
    end
    // Output lanes are deskewed so every lane of a row lands on d_o together.
    if (D == 0) begin : g_out0
      assign res[i*RW +: RW] = pe_prod[i*RW +: RW];
    end else begin : g_outn
      logic [RW-1:0] so [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) so[k] <= '0;
        end else if (abort) begin
          for (int k = 0; k < D; k++) so[k] <= '0;
        end else if (pe_en) begin
          so[0] <= pe_prod[i*RW +: RW];
          for (int k = 1; k < D; k++) so[k] <= so[k-1];
        end
      end
      assign res[i*RW +: RW] = so[D-1];
    end
  end
endmodule

// File: tb/tb_vmx_mm_sequencer.sv
// tb_vmx_mm_sequencer: directed bench with a behavioural weight-stationary PE array model.
module tb_vmx_mm_sequencer;
  localparam int P = 4, W = 16, LAT = 4;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, cfg_simd = 0, cfg_loop = 0;
  logic [7:0] cfg_rows = 0;
  logic in_valid = 0, in_ready, pe_en, wr_en, wr_ready = 1, busy, done;
  logic [P*W-1:0] d_i = 0, pe_vec;
  logic [8*P-1:0] pe_ctrl;
  logic [P-1:0] pe_simd;
  logic [2*P*W-1:0] pe_prod, d_o;
  logic [7:0] addr;
  logic [2:0] state_o;
  int n_checks = 0, n_fail = 0;

  vmx_mm_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_rows(cfg_rows),
    .cfg_simd(cfg_simd), .cfg_loop(cfg_loop), .in_valid(in_valid), .in_ready(in_ready),
    .d_i(d_i), .pe_en(pe_en), .pe_ctrl(pe_ctrl), .pe_simd(pe_simd), .pe_vec(pe_vec),
    .pe_prod(pe_prod), .wr_en(wr_en), .wr_ready(wr_ready), .d_o(d_o), .addr(addr),
    .busy(busy), .done(done), .state_o(state_o));

  always #5 clk = ~clk;

  // Array model: lane k of a row reaches the array k steps late; product lane j
  // appears P-1+LAT+j steps after the row entered, matching the tag depth.
  logic [W-1:0] vh [64][P];
  logic [W-1:0] wm [P][P];
  int s = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < 64; a++) for (int k = 0; k < P; k++) vh[a][k] <= '0;
      for (int a = 0; a < P; a++) for (int k = 0; k < P; k++) wm[a][k] <= '0;
    end else if (pe_en) begin
      for (int k = 0; k < P; k++) begin
        vh[s % 64][k] <= pe_vec[k*W +: W];
        if (pe_ctrl[8*k+7]) wm[pe_ctrl[8*k +: 2]][k] <= pe_vec[k*W +: W];
      end
      s <= s + 1;
    end
  end
  always_comb begin
    pe_prod = '0;
    for (int j = 0; j < P; j++) begin
      logic [31:0] acc;
      acc = 0;
      for (int k = 0; k < P; k++)
        acc = acc + 32'(wm[k][j]) * 32'(vh[(s - (P-1+LAT+j-k)) & 63][k]);
      pe_prod[j*32 +: 32] = acc;
    end
  end

  function automatic logic [P*W-1:0] drow(int r);
    logic [P*W-1:0] v;
    for (int k = 0; k < P; k++) v[k*W +: W] = 16'(r*16 + k*2 + 1);
    return v;
  endfunction
  function automatic logic [P*W-1:0] wrow(int w);
    logic [P*W-1:0] v;
    v = '0;
    if (w < P) v[w*W +: W] = 16'd1;
    return v;
  endfunction
  function automatic logic [2*P*W-1:0] exp_do(int r);
    logic [P*W-1:0] d;
    logic [2*P*W-1:0] e;
    d = drow(r);
    for (int j = 0; j < P; j++) e[j*32 +: 32] = 32'(d[j*W +: W]);
    return e;
  endfunction

  int setw_hs, load_hs, done_cnt, cyc_first_data, cyc_first_wr, stall_i, timed_out;
  logic [2:0] first_state;
  logic [8*P-1:0] first_ctrl;
  logic [7:0] wa[$];
  logic [2*P*W-1:0] wd[$];
  logic st_en[3], st_pe[3];
  logic [7:0] st_addr[3];
  logic [2*P*W-1:0] st_do[3];

  task automatic run_job(input logic [7:0] rows, input bit simd, input bit loop,
                         input bit toggle, input bit stall, input bit kill);
    int wi = 0, di = 0, cyc = 0;
    setw_hs = 0; load_hs = 0; done_cnt = 0; cyc_first_data = -1; cyc_first_wr = -1;
    stall_i = 0; timed_out = 0; first_ctrl = '0; wa.delete(); wd.delete();
    @(negedge clk); cfg_rows = rows; cfg_simd = simd; cfg_loop = loop; start = 1;
    @(negedge clk); start = 0; first_state = state_o;
    forever begin
      if (state_o == 3'd0) break;
      if (cyc >= 2000) begin timed_out = 1; break; end
      in_valid = (state_o == 3'd1 || state_o == 3'd2) && !(toggle && cyc % 2 == 1);
      d_i = (state_o == 3'd1) ? wrow(wi) : drow(di);
      wr_ready = !(stall && wa.size() == 1 && stall_i < 3);
      if (kill && state_o == 3'd3) begin
        abort = 1; in_valid = 0;
        @(negedge clk); abort = 0;
        break;
      end
      #1;
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        if (state_o == 3'd1) begin if (wi == 0) first_ctrl = pe_ctrl; setw_hs++; wi++; end
        else begin if (di == 0) cyc_first_data = cyc; load_hs++; di++; end
      end
      if (wr_en && cyc_first_wr < 0) cyc_first_wr = cyc;
      if (wr_en && wr_ready) begin wa.push_back(addr); wd.push_back(d_o); end
      if (!wr_ready) begin
        st_en[stall_i] = wr_en; st_pe[stall_i] = pe_en; st_addr[stall_i] = addr; st_do[stall_i] = d_o;
        stall_i++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 0; wr_ready = 1; d_i = '0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_checks += 10;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d expected 0", state_o); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b expected 0", wr_en); end
    if (addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %0d expected 0", addr); end
    if (pe_en !== 1'b1) begin n_fail++; $display("FAIL reset_pe_en got %b expected 1", pe_en); end
    if (pe_vec !== '0) begin n_fail++; $display("FAIL reset_pe_vec got %h expected 0", pe_vec); end
    if (pe_ctrl !== '0) begin n_fail++; $display("FAIL reset_pe_ctrl got %h expected 0", pe_ctrl); end
    if (d_o !== '0) begin n_fail++; $display("FAIL reset_d_o got %h expected 0", d_o); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_first_job;
    run_job(8'd4, 1, 0, 0, 0, 0);
    n_checks += 9;
    if (timed_out != 0) begin n_fail++; $display("FAIL first_timeout got %0d expected 0", timed_out); end
    if (first_state !== 3'd1) begin n_fail++; $display("FAIL first_state got %0d expected 1", first_state); end
    if (setw_hs != 4) begin n_fail++; $display("FAIL first_setw_hs got %0d expected 4", setw_hs); end
    if (load_hs != 4) begin n_fail++; $display("FAIL first_load_hs got %0d expected 4", load_hs); end
    if (cyc_first_wr - cyc_first_data != 10) begin n_fail++; $display("FAIL first_latency got %0d expected 10", cyc_first_wr - cyc_first_data); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL first_done got %0d expected 1", done_cnt); end
    if (first_ctrl !== 32'h0000_0080) begin n_fail++; $display("FAIL first_pe_ctrl got %h expected 00000080", first_ctrl); end
    if (pe_simd !== 4'hF) begin n_fail++; $display("FAIL first_pe_simd got %h expected f", pe_simd); end
    if (wa.size() != 4) begin n_fail++; $display("FAIL first_writes got %0d expected 4", wa.size()); end
    for (int i = 0; i < wa.size(); i++) begin
      n_checks += 2;
      if (wa[i] !== 8'(i)) begin n_fail++; $display("FAIL first_addr[%0d] got %0d expected %0d", i, wa[i], i); end
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL first_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  task automatic test_loop_job;
    run_job(8'd4, 0, 1, 0, 0, 0);
    n_checks += 6;
    if (timed_out != 0) begin n_fail++; $display("FAIL loop_timeout got %0d expected 0", timed_out); end
    if (first_state !== 3'd2) begin n_fail++; $display("FAIL loop_state got %0d expected 2", first_state); end
    if (setw_hs != 0) begin n_fail++; $display("FAIL loop_setw_hs got %0d expected 0", setw_hs); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL loop_done got %0d expected 1", done_cnt); end
    if (pe_simd !== 4'h0) begin n_fail++; $display("FAIL loop_pe_simd got %h expected 0", pe_simd); end
    if (wa.size() != 4) begin n_fail++; $display("FAIL loop_writes got %0d expected 4", wa.size()); end
    for (int i = 0; i < wa.size(); i++) begin
      n_checks += 2;
      if (wa[i] !== 8'(i)) begin n_fail++; $display("FAIL loop_addr[%0d] got %0d expected %0d", i, wa[i], i); end
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL loop_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  task automatic test_backpressure;
    run_job(8'd4, 0, 1, 0, 1, 0);
    n_checks += 3;
    if (timed_out != 0) begin n_fail++; $display("FAIL bp_timeout got %0d expected 0", timed_out); end
    if (stall_i != 3) begin n_fail++; $display("FAIL bp_stall_cycles got %0d expected 3", stall_i); end
    if (wa.size() != 4) begin n_fail++; $display("FAIL bp_writes got %0d expected 4", wa.size()); end
    for (int i = 0; i < stall_i; i++) begin
      n_checks += 4;
      if (st_en[i] !== 1'b1) begin n_fail++; $display("FAIL bp_wr_en[%0d] got %b expected 1", i, st_en[i]); end
      if (st_pe[i] !== 1'b0) begin n_fail++; $display("FAIL bp_pe_en[%0d] got %b expected 0", i, st_pe[i]); end
      if (st_addr[i] !== 8'd1) begin n_fail++; $display("FAIL bp_addr[%0d] got %0d expected 1", i, st_addr[i]); end
      if (st_do[i] !== exp_do(1)) begin n_fail++; $display("FAIL bp_d_o[%0d] got %h expected %h", i, st_do[i], exp_do(1)); end
    end
    for (int i = 0; i < wa.size(); i++) begin
      n_checks += 2;
      if (wa[i] !== 8'(i)) begin n_fail++; $display("FAIL bp_w_addr[%0d] got %0d expected %0d", i, wa[i], i); end
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL bp_w_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  task automatic test_bubbles;
    run_job(8'd6, 0, 1, 1, 0, 0);
    n_checks += 3;
    if (timed_out != 0) begin n_fail++; $display("FAIL bub_timeout got %0d expected 0", timed_out); end
    if (load_hs != 6) begin n_fail++; $display("FAIL bub_load_hs got %0d expected 6", load_hs); end
    if (wa.size() != 6) begin n_fail++; $display("FAIL bub_writes got %0d expected 6", wa.size()); end
    for (int i = 0; i < wa.size(); i++) begin
      n_checks += 2;
      if (wa[i] !== 8'(i)) begin n_fail++; $display("FAIL bub_addr[%0d] got %0d expected %0d", i, wa[i], i); end
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL bub_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  task automatic test_rows_bounds;
    run_job(8'd0, 0, 1, 0, 0, 0);
    n_checks += 2;
    if (load_hs != 4) begin n_fail++; $display("FAIL rows0_load_hs got %0d expected 4", load_hs); end
    if (wa.size() != 4) begin n_fail++; $display("FAIL rows0_writes got %0d expected 4", wa.size()); end
    run_job(8'd255, 0, 1, 0, 0, 0);
    n_checks += 3;
    if (timed_out != 0) begin n_fail++; $display("FAIL rows255_timeout got %0d expected 0", timed_out); end
    if (wa.size() != 255) begin n_fail++; $display("FAIL rows255_writes got %0d expected 255", wa.size()); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL rows255_done got %0d expected 1", done_cnt); end
    if (wa.size() > 0) begin
      n_checks++;
      if (wa[wa.size()-1] !== 8'd254) begin n_fail++; $display("FAIL rows255_last_addr got %0d expected 254", wa[wa.size()-1]); end
    end
    for (int i = 0; i < wa.size(); i++) begin
      n_checks += 2;
      if (wa[i] !== 8'(i)) begin n_fail++; $display("FAIL rows255_addr[%0d] got %0d expected %0d", i, wa[i], i); end
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL rows255_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  task automatic test_abort_start;
    @(negedge clk); start = 1; abort = 1; cfg_loop = 0;
    @(negedge clk); start = 0; abort = 0;
    n_checks += 2;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_start_state got %0d expected 0", state_o); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy got %b expected 0", busy); end
  endtask

  task automatic test_abort_drain;
    run_job(8'd4, 0, 1, 0, 0, 1);
    n_checks += 3;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_state got %0d expected 0", state_o); end
    if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done got %0d expected 0", done_cnt); end
    if (wa.size() != 0) begin n_fail++; $display("FAIL abort_writes got %0d expected 0", wa.size()); end
    for (int i = 0; i < 12; i++) begin
      n_checks += 2;
      if (wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_wr_en[%0d] got %b expected 0", i, wr_en); end
      if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_pulse[%0d] got %b expected 0", i, done); end
      @(negedge clk);
    end
    run_job(8'd2, 0, 1, 0, 0, 0);
    n_checks += 4;
    if (first_state !== 3'd1) begin n_fail++; $display("FAIL abort_next_state got %0d expected 1", first_state); end
    if (setw_hs != 4) begin n_fail++; $display("FAIL abort_next_setw got %0d expected 4", setw_hs); end
    if (wa.size() != 2) begin n_fail++; $display("FAIL abort_next_writes got %0d expected 2", wa.size()); end
    if (wd.size() == 2) begin
      n_checks++;
      if (wd[1] !== exp_do(1)) begin n_fail++; $display("FAIL abort_next_d_o got %h expected %h", wd[1], exp_do(1)); end
    end
    if (done_cnt != 1) begin n_fail++; $display("FAIL abort_next_done got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_job;
    @(negedge clk); cfg_rows = 4; cfg_loop = 1; start = 1;
    @(negedge clk); start = 0; in_valid = 1; d_i = drow(0);
    n_checks++;
    if (state_o !== 3'd2) begin n_fail++; $display("FAIL rmid_state got %0d expected 2", state_o); end
    @(negedge clk); #3 rst_n = 0; #1;
    n_checks += 3;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL rmid_async_state got %0d expected 0", state_o); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b expected 0", busy); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready got %b expected 0", in_ready); end
    @(negedge clk); in_valid = 0; rst_n = 1;
    run_job(8'd4, 0, 1, 0, 0, 0);
    n_checks += 4;
    if (first_state !== 3'd1) begin n_fail++; $display("FAIL rmid_next_state got %0d expected 1", first_state); end
    if (setw_hs != 4) begin n_fail++; $display("FAIL rmid_setw got %0d expected 4", setw_hs); end
    if (wa.size() != 4) begin n_fail++; $display("FAIL rmid_writes got %0d expected 4", wa.size()); end
    if (done_cnt != 1) begin n_fail++; $display("FAIL rmid_done got %0d expected 1", done_cnt); end
    for (int i = 0; i < wd.size(); i++) begin
      n_checks++;
      if (wd[i] !== exp_do(i)) begin n_fail++; $display("FAIL rmid_d_o[%0d] got %h expected %h", i, wd[i], exp_do(i)); end
    end
  endtask

  initial begin
    test_reset;
    test_first_job;
    test_loop_job;
    test_backpressure;
    test_bubbles;
    test_rows_bounds;
    test_abort_start;
    test_abort_drain;
    test_reset_mid_job;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
